// File: rtl/axis_slave_pkg.sv
// Shared types and constants for the AXI-Stream slave FIFO block.
package axis_slave_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    OVERRUN = 2'd2
  } state_t;

  localparam int pkt_cnt_w = 16;

endpackage

// File: rtl/axis_slave_fifo_if.sv
// AXI-Stream beat channel between the stream master and the slave FIFO.
interface axis_slave_fifo_if #(
  parameter int data_width = 4
);
  logic [data_width-1:0] s_data;
  logic                  s_valid;
  logic                  s_tlast;
  logic                  s_ready;

  modport master (output s_data, output s_valid, output s_tlast, input s_ready);
  modport slave  (input s_data, input s_valid, input s_tlast, output s_ready);
endinterface

// File: rtl/axis_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered occupancy count.
module axis_sync_fifo #(
  parameter int data_width = 4,
  parameter int fifo_aw    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [data_width-1:0] wr_data,
  output logic [data_width-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [fifo_aw:0]      count
);

  localparam int unsigned depth = 2 ** fifo_aw;

  logic [data_width-1:0] mem [depth];
  logic [fifo_aw-1:0]    wr_ptr;
  logic [fifo_aw-1:0]    rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (fifo_aw + 1)'(depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head word is forced to zero while empty so the read port reads 0 out of reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + fifo_aw'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + fifo_aw'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (fifo_aw + 1)'(1);
        2'b01:   count <= count - (fifo_aw + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axis_slave_fifo.sv
// AXI-Stream slave: buffers beats in a FWFT FIFO and checks packet length.
module axis_slave_fifo
  import axis_slave_pkg::*;
#(
  parameter int data_width  = 4,
  parameter int trans_width = 8,
  parameter int trans_lenth = 2 ** trans_width,
  parameter int fifo_aw     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  axis_slave_fifo_if.slave      s,
  input  logic                  rd_en,
  output logic [data_width-1:0] rd_data,
  output logic                  rd_valid,
  output logic [fifo_aw:0]      fifo_count,
  output logic                  pkt_done,
  output logic                  len_err,
  output logic [pkt_cnt_w-1:0]  pkt_cnt
);

  localparam logic [trans_width-1:0] last_idx = trans_width'(trans_lenth - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [trans_width-1:0] beat_idx;
  logic [trans_width-1:0] beat_idx_nxt;
  logic                   done_nxt;
  logic                   err_nxt;
  logic [pkt_cnt_w-1:0]   pkt_cnt_nxt;
  logic                   running;
  logic                   full;
  logic                   empty;
  logic                   accept;
  logic                   pop;

  // Holds s_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
    end else begin
      running <= 1'b1;
    end
  end

  assign s.s_ready = running && !full;
  assign accept    = s.s_valid && s.s_ready;
  assign pop       = rd_en && !empty;
  assign rd_valid  = !empty;

  axis_sync_fifo #(
    .data_width (data_width),
    .fifo_aw    (fifo_aw)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .pop     (pop),
    .wr_data (s.s_data),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat_idx <= '0;
      pkt_done <= 1'b0;
      len_err  <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      beat_idx <= beat_idx_nxt;
      pkt_done <= done_nxt;
      len_err  <= err_nxt;
      pkt_cnt  <= pkt_cnt_nxt;
    end
  end

  // IDLE and RECV share one rule set so a single-beat packet works when trans_lenth is 1.
  always_comb begin
    state_nxt    = state;
    beat_idx_nxt = beat_idx;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    pkt_cnt_nxt  = pkt_cnt;
    if (accept) begin
      beat_idx_nxt = s.s_tlast ? '0 : beat_idx + trans_width'(1);
      unique case (state)
        IDLE, RECV: begin
          if (s.s_tlast) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
            if (beat_idx == last_idx) begin
              pkt_cnt_nxt = pkt_cnt + pkt_cnt_w'(1);
            end else begin
              err_nxt = 1'b1;
            end
          end else if (beat_idx == last_idx) begin
            err_nxt   = 1'b1;
            state_nxt = OVERRUN;
          end else begin
            state_nxt = RECV;
          end
        end
        OVERRUN: begin
          if (s.s_tlast) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_slave_fifo.sv
// Bench for axis_slave_fifo: vector table, directed sequences and a queue-based reference model.
module tb_axis_slave_fifo;

  localparam int L     = 256;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en;
  logic [3:0]  rd_data;
  logic        rd_valid;
  logic [4:0]  fifo_count;
  logic        pkt_done;
  logic        len_err;
  logic [15:0] pkt_cnt;

  axis_slave_fifo_if #(.data_width(4)) sif ();

  axis_slave_fifo #(
    .data_width  (4),
    .trans_width (8),
    .trans_lenth (L),
    .fifo_aw     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s          (sif),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_count (fifo_count),
    .pkt_done   (pkt_done),
    .len_err    (len_err),
    .pkt_cnt    (pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of stored beats plus beats seen in the current packet.
  logic [3:0]  q[$];
  int          m_n;
  logic [15:0] m_cnt;
  logic        m_done, m_err, m_run;
  logic        last_acc;
  int          t_done, t_err, t_both, t_acc, t_pop;

  typedef struct {
    logic       v, t;
    logic [3:0] d;
    logic       r;
    logic       e_ready, e_rv;
    logic [3:0] e_data;
    logic [4:0] e_cnt;
    logic       e_done, e_err;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_tally();
    t_done = 0; t_err = 0; t_both = 0; t_acc = 0; t_pop = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sif.s_valid = 1'b0; sif.s_tlast = 1'b0; sif.s_data = '0; rd_en = 1'b0;
    #1;
    check("rst_s_ready", sif.s_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_len_err", len_err, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    repeat (2) @(negedge clk);
    q.delete();
    m_n = 0; m_cnt = '0; m_done = 1'b0; m_err = 1'b0; m_run = 1'b0;
    rst = 1'b0;
  endtask

  // Called just after a falling edge with inputs driven: compares, predicts the next edge, advances.
  task automatic cycle();
    logic exp_ready, acc, pop;
    #1;
    exp_ready = m_run && (q.size() < DEPTH);
    check("s_ready", sif.s_ready, exp_ready);
    check("rd_valid", rd_valid, q.size() > 0);
    check("rd_data", rd_data, (q.size() > 0) ? q[0] : 4'h0);
    check("fifo_count", fifo_count, q.size());
    check("pkt_done", pkt_done, m_done);
    check("len_err", len_err, m_err);
    check("pkt_cnt", pkt_cnt, m_cnt);
    if (pkt_done === 1'b1) t_done++;
    if (len_err === 1'b1) t_err++;
    if (pkt_done === 1'b1 && len_err === 1'b1) t_both++;
    acc = sif.s_valid && exp_ready;
    pop = rd_en && (q.size() > 0);
    if (acc) t_acc++;
    if (pop) begin t_pop++; void'(q.pop_front()); end
    if (acc) q.push_back(sif.s_data);
    m_done = 1'b0; m_err = 1'b0;
    if (acc) begin
      m_n++;
      if (sif.s_tlast) begin
        m_done = 1'b1;
        if (m_n == L) m_cnt++;
        else if (m_n < L) m_err = 1'b1;
        m_n = 0;
      end else if (m_n == L) begin
        m_err = 1'b1;
      end
    end
    m_run = 1'b1;
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_stream(input int nbeats, input int tlast_idx, input int vpct, input int rpct);
    int i = 0;
    int cyc = 0;
    sif.s_valid = 1'b0;
    while (i < nbeats && cyc < 5000) begin
      if (!sif.s_valid) sif.s_valid = ($urandom_range(99) < vpct);
      sif.s_data  = 4'(i % 16);
      sif.s_tlast = (i == tlast_idx);
      rd_en       = ($urandom_range(99) < rpct);
      cycle();
      if (last_acc) begin i++; sif.s_valid = 1'b0; end
      cyc++;
    end
    check("stream_budget", i, nbeats);
    sif.s_valid = 1'b0; sif.s_tlast = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    sif.s_valid = 1'b0; sif.s_tlast = 1'b0; rd_en = 1'b1;
    while (q.size() > 0 && cyc < 2000) begin cycle(); cyc++; end
    check("drain_budget", q.size(), 0);
    cycle(); cycle();
    rd_en = 1'b0;
  endtask

  initial begin
    int bi;
    tbl[0] = '{1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 4'h5, 1'b0, 1'b1, 1'b0, 4'h0, 5'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 4'h5, 5'd1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h5, 5'd2, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'hA, 5'd1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 4'h3, 1'b1, 1'b1, 1'b0, 4'h0, 5'd0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 4'hC, 1'b1, 1'b1, 1'b1, 4'h3, 5'd1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'hC, 5'd1, 1'b0, 1'b0};

    sif.s_valid = 1'b0; sif.s_tlast = 1'b0; sif.s_data = '0; rd_en = 1'b0;
    @(negedge clk);
    do_reset();

    // Hand-derived vectors: release, early tlast, FWFT pops, empty pop, simultaneous push/pop.
    for (int k = 0; k < 8; k++) begin
      sif.s_valid = tbl[k].v; sif.s_tlast = tbl[k].t; sif.s_data = tbl[k].d; rd_en = tbl[k].r;
      #1;
      check($sformatf("vec%0d_s_ready", k), sif.s_ready, tbl[k].e_ready);
      check($sformatf("vec%0d_rd_valid", k), rd_valid, tbl[k].e_rv);
      check($sformatf("vec%0d_rd_data", k), rd_data, tbl[k].e_data);
      check($sformatf("vec%0d_fifo_count", k), fifo_count, tbl[k].e_cnt);
      check($sformatf("vec%0d_pkt_done", k), pkt_done, tbl[k].e_done);
      check($sformatf("vec%0d_len_err", k), len_err, tbl[k].e_err);
      check($sformatf("vec%0d_pkt_cnt", k), pkt_cnt, 0);
      @(posedge clk);
      @(negedge clk);
    end

    // Correct 256-beat packet with the consumer always ready.
    do_reset(); clr_tally();
    run_stream(256, 255, 100, 100);
    drain();
    check("good_done_pulses", t_done, 1);
    check("good_err_pulses", t_err, 0);
    check("good_pkt_cnt", pkt_cnt, 1);
    check("good_pops", t_pop, 256);

    // Early tlast on beat 9, then a correct packet.
    do_reset(); clr_tally();
    run_stream(10, 9, 100, 100);
    drain();
    check("early_done_pulses", t_done, 1);
    check("early_err_pulses", t_err, 1);
    check("early_together", t_both, 1);
    check("early_pkt_cnt", pkt_cnt, 0);
    run_stream(256, 255, 80, 70);
    drain();
    check("early_next_pkt_cnt", pkt_cnt, 1);

    // Missing tlast on beat 255, tlast on beat 259.
    do_reset(); clr_tally();
    run_stream(260, 259, 100, 100);
    drain();
    check("miss_err_pulses", t_err, 1);
    check("miss_done_pulses", t_done, 1);
    check("miss_together", t_both, 0);
    check("miss_pkt_cnt", pkt_cnt, 0);
    check("miss_pops", t_pop, 260);

    // Backpressure: fill, pop once, refill one slot.
    do_reset(); clr_tally();
    bi = 0;
    for (int c = 0; c < 20; c++) begin
      sif.s_valid = 1'b1; sif.s_data = 4'(bi % 16); sif.s_tlast = 1'b0; rd_en = 1'b0;
      cycle();
      if (last_acc) bi++;
    end
    #1;
    check("bp_full_count", fifo_count, 16);
    check("bp_ready_low", sif.s_ready, 0);
    check("bp_accepts_full", t_acc, 16);
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    #1;
    check("bp_count_after_pop", fifo_count, 15);
    check("bp_ready_after_pop", sif.s_ready, 1);
    for (int c = 0; c < 8 && bi < 17; c++) begin
      sif.s_valid = 1'b1; sif.s_data = 4'(bi % 16);
      cycle();
      if (last_acc) bi++;
    end
    sif.s_valid = 1'b0;
    drain();
    check("bp_accepts_total", t_acc, 17);
    check("bp_pops_total", t_pop, 17);

    // Reset in the middle of a packet.
    do_reset(); clr_tally();
    run_stream(100, -1, 100, 50);
    do_reset(); clr_tally();
    run_stream(256, 255, 90, 80);
    drain();
    check("rst_mid_pkt_cnt", pkt_cnt, 1);
    check("rst_mid_err_pulses", t_err, 0);
    check("rst_mid_done_pulses", t_done, 1);

    // Randomised mix of correct, early and overrun packets against the model.
    do_reset(); clr_tally();
    for (int p = 0; p < 6; p++) begin
      int kind, n;
      kind = $urandom_range(2);
      if (kind == 0) n = L;
      else if (kind == 1) n = $urandom_range(L - 1, 1);
      else n = L + $urandom_range(8, 1);
      run_stream(n, n - 1, $urandom_range(100, 50), $urandom_range(100, 30));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_slave_fifo.md
Name: axis_slave_fifo

Overview:
- AXI-Stream slave that sits directly downstream of the stream master. Consumes its data/valid/tlast stream and drives ready.
- Buffers accepted beats in a local synchronous FIFO and presents them on a first-word-fall-through read port.
- Checks every packet against the fixed transfer length trans_lenth and reports completed packets and length errors.

Parameters:
- data_width, 4, width of each stream beat.
- trans_width, 8, width of the beat-index counter.
- trans_lenth, 2**trans_width, expected beats per packet (tlast on beat index trans_lenth-1).
- fifo_aw, 4, FIFO address width; depth = 2**fifo_aw.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  data_width  stream beat from the master.
- s_valid  in  1  master beat valid.
- s_tlast  in  1  last beat of packet.
- s_ready  out  1  slave can accept a beat.
- rd_en  in  1  pop request from the downstream consumer.
- rd_data  out  data_width  FIFO head word; valid while rd_valid=1.
- rd_valid  out  1  FIFO not empty.
- fifo_count  out  fifo_aw+1  current occupancy, 0..2**fifo_aw.
- pkt_done  out  1  one-cycle pulse when a packet's tlast beat is accepted.
- len_err  out  1  one-cycle pulse on a length violation.
- pkt_cnt  out  16  count of packets completed with correct length; wraps at 65535->0.

Behaviour:
- Reset values: s_ready=0, rd_valid=0, rd_data=0, fifo_count=0, pkt_done=0, len_err=0, pkt_cnt=0, beat index=0, state=IDLE, FIFO empty.
- Reset mid-packet discards the partial packet and all FIFO contents. s_ready rises in the first cycle after rst deasserts.
- s_ready = !full, decoded combinationally from registered occupancy.
- Accept (push) occurs when s_valid && s_ready at a rising edge. The slave never drops an accepted beat. While s_valid is high and s_ready is low, the master holds its data.
- Full FIFO with rd_en in the same cycle: no push that cycle, because s_ready is already 0. s_ready returns to 1 in the cycle after the pop.
- Pop occurs when rd_en && rd_valid. rd_en while empty is ignored.
- Push and pop in the same cycle (non-empty, non-full): fifo_count is unchanged and ordering is preserved.
- Push into an empty FIFO: rd_valid and rd_data update in the next cycle, so latency is 1 cycle from accept to visibility.
- Beat index (trans_width bits) increments on every accept and clears to 0 on an accepted tlast beat.
- State machine (all transitions on accepted beats only):
  - IDLE: the first beat moves to RECV, unless it is also tlast, which is handled as below.
  - RECV:
    - Accept with tlast and index == trans_lenth-1 -> pkt_done=1, pkt_cnt+1, go to IDLE.
    - Accept with tlast and index < trans_lenth-1 (early tlast) -> pkt_done=1, len_err=1, pkt_cnt unchanged, go to IDLE.
    - Accept without tlast and index == trans_lenth-1 (missing tlast) -> len_err=1, go to OVERRUN.
  - OVERRUN: keep accepting and storing beats with no further len_err. An accepted tlast -> pkt_done=1, pkt_cnt unchanged, go to IDLE.
- pkt_done and len_err are registered pulses asserted in the cycle after the triggering accept.
- When trans_lenth=1, a single tlast beat accepted from IDLE is a correct packet.

Decomposition:
- Package axis_slave_pkg holds the state enum (IDLE, RECV, OVERRUN) and a constant for the pkt_cnt width (16).
- Sub-module axis_sync_fifo: parameterised by data_width and fifo_aw, first-word-fall-through, with push, pop, full, empty and count ports.
- The top level holds the handshake logic, beat counter, FSM and status registers.

Test Plan:
- Correct packet: 256 beats with data = index mod 16, tlast on beat 255, rd_en held 1 -> rd_data sequence 0..15 repeating; exactly one pkt_done; len_err never; pkt_cnt=1.
- Early tlast: tlast on beat 9 -> pkt_done and len_err pulse together one cycle later; pkt_cnt=0; next packet of 256 beats gives pkt_cnt=1.
- Missing tlast: no tlast on beat 255; tlast on beat 259 -> len_err once, after beat 255; pkt_done once, after beat 259; pkt_cnt=0; all 260 beats are readable.
- Backpressure: rd_en=0 and s_valid held 1 -> s_ready drops after 16 accepts with fifo_count=16. A single rd_en pulse gives fifo_count=15 and s_ready=1 in the next cycle; exactly 17 beats are accepted in order.
- Reset mid-packet: assert rst after 100 beats -> immediately s_ready=0, rd_valid=0, fifo_count=0. After release, a 256-beat packet yields pkt_cnt=1 and no len_err.
